mem_line_ctr: RTL and testbench
===============================

Name: mem_line_ctr

Overview:
- Synthesizable, parametrised successor of the behavioural MemCTR model.
- Serves whole cache lines over bus 2 with a fixed access latency, configurable line size and data-bus width.
- Sits behind the cache on bus 2. Uses split unidirectional command/data ports instead of inout wires, so it synthesizes and needs no bus-ownership turnaround.
- Backing store is an internal byte array, little-endian within each beat.

Parameters:
- LINE_ADDR_W, 10: width of the line address on A_IN.
- OFFSET_W, 4: log2 of line size in bytes (default 16-byte line).
- DATA_W, 16: data-bus width in bits. Must be a multiple of 8, and DATA_W/8 must divide 2**OFFSET_W.
- MEM_CTR_DELAY, 100: cycles from command acceptance to first read beat or to the write response. Must be >= 1.
- Derived: BEAT_BYTES = DATA_W/8; BEATS = 2**OFFSET_W / BEAT_BYTES; MEM_BYTES = 2**(LINE_ADDR_W+OFFSET_W).

Ports:
- CLK  in  1  clock; all activity on posedge.
- RESET_N  in  1  asynchronous active-low reset.
- C_IN  in  2  command: 00 NOP, 10 READ_LINE, 11 WRITE_LINE; 01 is reserved and treated as NOP.
- A_IN  in  LINE_ADDR_W  line address; sampled with the command only.
- D_IN  in  DATA_W  write beats; byte 0 is bits [7:0] and maps to the lowest address.
- C_OUT  out  2  00 NOP, 01 RESPONSE.
- D_OUT  out  DATA_W  read beats, same byte order as D_IN.
- BUSY  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: async assert forces state IDLE, C_OUT=NOP, D_OUT=0, BUSY=0, counters=0. RAM contents are not cleared.
- Reset mid-operation abandons the transfer. Beats already written remain in RAM.
- States: IDLE, RD_WAIT, RD_SEND, WR_RECV, WR_WAIT, RESP.
- Commands are accepted only in IDLE. "Cycle 0" is the posedge at which a command is sampled; base = {A_IN, OFFSET_W zeros} is latched at that edge.
- READ_LINE:
  - IDLE -> RD_WAIT, latency counter loaded.
  - RD_SEND begins at cycle MEM_CTR_DELAY. At cycles MEM_CTR_DELAY+k, k=0..BEATS-1: C_OUT=RESPONSE, D_OUT = bytes base+k*BEAT_BYTES .. +BEAT_BYTES-1.
  - RESPONSE is held continuously across all beats.
  - At cycle MEM_CTR_DELAY+BEATS: C_OUT=NOP, D_OUT=0, state IDLE. A new command may be sampled at that same edge.
- WRITE_LINE:
  - Beat k is sampled from D_IN at cycle k, k=0..BEATS-1; beat 0 is sampled together with the command. Each beat is written to RAM immediately (WR_RECV).
  - The latency counter runs in parallel with beat reception. WR_WAIT covers any remaining latency.
  - C_OUT=RESPONSE for exactly one cycle at cycle max(MEM_CTR_DELAY, BEATS); D_OUT stays 0.
  - Next edge returns to IDLE, so the next command is accepted at cycle max(...)+1.
- Commands arriving while BUSY=1 are ignored: no state change, no RAM effect.
- Address arithmetic wraps modulo MEM_BYTES; line-aligned bases never cross a line.
- Counters sized $clog2(max(MEM_CTR_DELAY,BEATS)+1). With BEATS=1, read sends a single-beat RESPONSE.
- A read immediately following a write to the same line returns the newly written data; there is no read-during-write hazard because the phases never overlap.

Optional Feature:
- Macro MEM_CMD_ERR_EN.
- When defined, adds output ERR (1 bit) and output ERR_CNT (8 bits, saturating at 255), both reset to 0.
  - ERR pulses high for one cycle at the edge after any non-NOP C_IN is sampled while BUSY=1 or C_IN=01.
  - ERR_CNT increments on each such pulse.
- When undefined, these ports do not exist and such commands are silently ignored.

Test Plan (MEM_CTR_DELAY=4, DATA_W=16, OFFSET_W=4):
- WRITE_LINE A_IN=3 with D_IN=16'h0100,16'h0302,...,16'h0F0E on cycles 0..7 -> C_OUT=RESPONSE only at cycle 8; RAM[48..63] = 0x00..0x0F.
- READ_LINE A_IN=3 after the above -> C_OUT=NOP cycles 1..3; RESPONSE cycles 4..11 with D_OUT=16'h0100..16'h0F0E; NOP at cycle 12; BUSY falls at 12.
- Delay 20, WRITE_LINE -> RESPONSE exactly at cycle 20 (latency-bound, not beat-bound); READ_LINE issued at cycle 21 is accepted.
- READ_LINE issued at cycle 2 of an ongoing read -> ignored, only one 8-beat burst. With MEM_CMD_ERR_EN: ERR=1 at cycle 3, ERR_CNT=1.
- RESET_N pulsed low at cycle 3 of a write -> C_OUT=NOP and BUSY=0 immediately; RAM holds beats 0..2 (6 bytes) and the old data elsewhere in the line.
- LINE_ADDR_W=10, A_IN=10'h3FF write/read -> bytes 16368..16383 round-trip with no wrap into line 0.

Source files
------------

// File: rtl/mem_line_ctr.sv
// rtl/mem_line_ctr.sv - bus-2 cache-line memory controller with fixed access latency; optional MEM_CMD_ERR_EN adds ERR/ERR_CNT
module mem_line_ctr #(
  parameter int LINE_ADDR_W   = 10,
  parameter int OFFSET_W      = 4,
  parameter int DATA_W        = 16,
  parameter int MEM_CTR_DELAY = 100
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [1:0]             C_IN,
  input  logic [LINE_ADDR_W-1:0] A_IN,
  input  logic [DATA_W-1:0]      D_IN,
  output logic [1:0]             C_OUT,
  output logic [DATA_W-1:0]      D_OUT,
  output logic                   BUSY
`ifdef MEM_CMD_ERR_EN
  ,
  output logic                   ERR,
  output logic [7:0]             ERR_CNT
`endif
);

  localparam int BEAT_BYTES = DATA_W / 8;
  localparam int BEATS      = (2 ** OFFSET_W) / BEAT_BYTES;
  localparam int ADDR_W     = LINE_ADDR_W + OFFSET_W;
  localparam int MEM_BYTES  = 2 ** ADDR_W;
  localparam int CNT_MAX    = (MEM_CTR_DELAY > BEATS) ? MEM_CTR_DELAY : BEATS;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int BEAT_SH    = $clog2(BEAT_BYTES);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_CTR_DELAY - 1);
  localparam logic [CNT_W-1:0] BEATS_C  = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_RSV = 2'b01;
  localparam logic [1:0] CMD_RD  = 2'b10;
  localparam logic [1:0] CMD_WR  = 2'b11;
  localparam logic [1:0] OUT_NOP = 2'b00;
  localparam logic [1:0] OUT_RSP = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_SEND,
    S_WR_RECV,
    S_WR_WAIT,
    S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       lat_q, lat_d;
  logic [CNT_W-1:0]       beat_q, beat_d;
  logic [LINE_ADDR_W-1:0] line_q, line_d;
  logic [1:0]             c_out_q, c_out_d;
  logic [DATA_W-1:0]      d_out_q, d_out_d;

  logic                   accept;
  logic                   wr_en;
  logic [LINE_ADDR_W-1:0] wr_line;
  logic [OFFSET_W-1:0]    wr_off;
  logic [OFFSET_W-1:0]    rd_off;
  logic [DATA_W-1:0]      rd_beat;

  logic [7:0] mem [MEM_BYTES];

  // Current read beat, assembled little-endian from the byte store.
  always_comb begin
    rd_off  = OFFSET_W'(beat_q) << BEAT_SH;
    rd_beat = '0;
    for (int j = 0; j < BEAT_BYTES; j++) begin
      rd_beat[8*j +: 8] = mem[{line_q, rd_off + OFFSET_W'(j)}];
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    line_d  = line_q;
    c_out_d = OUT_NOP;
    d_out_d = '0;
    accept  = 1'b0;
    wr_en   = 1'b0;
    wr_line = line_q;
    wr_off  = OFFSET_W'(beat_q) << BEAT_SH;

    case (state_q)
      S_IDLE: accept = 1'b1;
      S_RD_WAIT: begin
        if (lat_q == '0) begin
          state_d = S_RD_SEND;
          c_out_d = OUT_RSP;
          d_out_d = rd_beat;
          beat_d  = beat_q + CNT_ONE;
        end else begin
          lat_d = lat_q - CNT_ONE;
        end
      end
      S_RD_SEND: begin
        // The edge that drops RESPONSE after the last beat can already take a command.
        if (beat_q == BEATS_C) begin
          accept = 1'b1;
        end else begin
          c_out_d = OUT_RSP;
          d_out_d = rd_beat;
          beat_d  = beat_q + CNT_ONE;
        end
      end
      S_WR_RECV: begin
        wr_en  = 1'b1;
        beat_d = beat_q + CNT_ONE;
        if (beat_q == BEATS_C - CNT_ONE) state_d = S_WR_WAIT;
        if (lat_q != '0) lat_d = lat_q - CNT_ONE;
      end
      S_WR_WAIT: begin
        if (lat_q == '0) begin
          state_d = S_RESP;
          c_out_d = OUT_RSP;
        end else begin
          lat_d = lat_q - CNT_ONE;
        end
      end
      S_RESP: accept = 1'b1;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d = S_IDLE;
      beat_d  = '0;
      if (C_IN == CMD_RD) begin
        state_d = S_RD_WAIT;
        line_d  = A_IN;
        lat_d   = LAT_LOAD;
      end else if (C_IN == CMD_WR) begin
        // Beat 0 arrives together with the command.
        state_d = (BEATS == 1) ? S_WR_WAIT : S_WR_RECV;
        line_d  = A_IN;
        lat_d   = LAT_LOAD;
        beat_d  = CNT_ONE;
        wr_en   = 1'b1;
        wr_line = A_IN;
        wr_off  = '0;
      end
    end

    if (!RESET_N) wr_en = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      line_q  <= '0;
      c_out_q <= OUT_NOP;
      d_out_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      c_out_q <= c_out_d;
      d_out_q <= d_out_d;
    end
  end

  // Byte store is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int j = 0; j < BEAT_BYTES; j++) begin
        mem[{wr_line, wr_off + OFFSET_W'(j)}] <= D_IN[8*j +: 8];
      end
    end
  end

  assign C_OUT = c_out_q;
  assign D_OUT = d_out_q;
  assign BUSY  = (state_q != S_IDLE);

`ifdef MEM_CMD_ERR_EN
  logic       err_q, err_d;
  logic [7:0] err_cnt_q;

  always_comb begin
    err_d = 1'b0;
    if (C_IN != CMD_NOP && (!accept || C_IN == CMD_RSV)) err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= err_d;
      if (err_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign ERR     = err_q;
  assign ERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_line_ctr.sv
// tb/tb_mem_line_ctr.sv - directed bench for mem_line_ctr (delay 4 and delay 20 instances)
`timescale 1ns/1ps
module tb_mem_line_ctr;

  localparam int LAW   = 10;
  localparam int DW    = 16;
  localparam int BEATS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [1:0]     c_in, c_out;
  logic [LAW-1:0] a_in;
  logic [DW-1:0]  d_in, d_out;
  logic           busy;
  logic [1:0]     c_in20, c_out20;
  logic [LAW-1:0] a_in20;
  logic [DW-1:0]  d_in20, d_out20;
  logic           busy20;
`ifdef MEM_CMD_ERR_EN
  logic           err, err20;
  logic [7:0]     err_cnt, err_cnt20;
  int             err_exp = 0;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] ref_mem [1 << 14];

  mem_line_ctr #(.LINE_ADDR_W(LAW), .OFFSET_W(4), .DATA_W(DW), .MEM_CTR_DELAY(4)) u_d4 (
    .CLK(clk), .RESET_N(rst_n), .C_IN(c_in), .A_IN(a_in), .D_IN(d_in),
    .C_OUT(c_out), .D_OUT(d_out), .BUSY(busy)
`ifdef MEM_CMD_ERR_EN
    , .ERR(err), .ERR_CNT(err_cnt)
`endif
  );

  mem_line_ctr #(.LINE_ADDR_W(LAW), .OFFSET_W(4), .DATA_W(DW), .MEM_CTR_DELAY(20)) u_d20 (
    .CLK(clk), .RESET_N(rst_n), .C_IN(c_in20), .A_IN(a_in20), .D_IN(d_in20),
    .C_OUT(c_out20), .D_OUT(d_out20), .BUSY(busy20)
`ifdef MEM_CMD_ERR_EN
    , .ERR(err20), .ERR_CNT(err_cnt20)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] line_beat(input logic [9:0] line, input int k);
    return {ref_mem[{line, 4'(2*k+1)}], ref_mem[{line, 4'(2*k)}]};
  endfunction

  task automatic wr4(input logic [9:0] line, input logic [7:0] seed);
    for (int k = 0; k < BEATS; k++) begin
      c_in = (k == 0) ? 2'b11 : 2'b00;
      a_in = (k == 0) ? line : ~line;
      d_in = {seed + 8'(2*k+1), seed + 8'(2*k)};
      ref_mem[{line, 4'(2*k)}]   = seed + 8'(2*k);
      ref_mem[{line, 4'(2*k+1)}] = seed + 8'(2*k+1);
      tick();
      chk("wr_busy", 32'(busy), 32'd1);
      chk("wr_cout_nop", 32'(c_out), 32'd0);
    end
    c_in = 2'b00;
    d_in = '0;
    tick();
    chk("wr_resp", 32'(c_out), 32'd1);
    chk("wr_resp_dout", 32'(d_out), 32'd0);
  endtask

  task automatic rd4(input logic [9:0] line, input bit inject);
    c_in = 2'b10;
    a_in = line;
    tick();
    c_in = 2'b00;
    a_in = ~line;
    chk("rd_busy", 32'(busy), 32'd1);
    for (int n = 1; n <= 3; n++) begin
      if (inject && n == 3) c_in = 2'b10;
      tick();
      c_in = 2'b00;
      chk("rd_wait_cout", 32'(c_out), 32'd0);
`ifdef MEM_CMD_ERR_EN
      if (inject && n == 3) begin
        err_exp++;
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_cnt", 32'(err_cnt), 32'(err_exp));
      end
`endif
    end
    for (int k = 0; k < BEATS; k++) begin
      tick();
      chk("rd_resp", 32'(c_out), 32'd1);
      chk("rd_data", 32'(d_out), 32'(line_beat(line, k)));
`ifdef MEM_CMD_ERR_EN
      if (k == 0) chk("err_clear", 32'(err), 32'd0);
`endif
    end
    tick();
    chk("rd_end_cout", 32'(c_out), 32'd0);
    chk("rd_end_dout", 32'(d_out), 32'd0);
    chk("rd_end_busy", 32'(busy), 32'd0);
    tick();
    chk("rd_no_second_burst", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    c_in   = 2'b00; a_in   = '0; d_in   = '0;
    c_in20 = 2'b00; a_in20 = '0; d_in20 = '0;
    #22;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);
    chk("rst_dout", 32'(d_out), 32'd0);
    chk("rst_busy20", 32'(busy20), 32'd0);
`ifdef MEM_CMD_ERR_EN
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reserved command behaves as NOP.
    c_in = 2'b01;
    a_in = 10'd7;
    tick();
    c_in = 2'b00;
    chk("rsv_busy", 32'(busy), 32'd0);
`ifdef MEM_CMD_ERR_EN
    err_exp++;
    chk("rsv_err", 32'(err), 32'd1);
    chk("rsv_err_cnt", 32'(err_cnt), 32'(err_exp));
`endif
    tick();

    // Latency-bound write: response at cycle 20, read accepted at cycle 21.
    for (int k = 0; k < BEATS; k++) begin
      c_in20 = (k == 0) ? 2'b11 : 2'b00;
      a_in20 = 10'd1;
      d_in20 = {8'(2*k+1) + 8'h10, 8'(2*k) + 8'h10};
      tick();
      chk("d20_wr_cout_nop", 32'(c_out20), 32'd0);
    end
    c_in20 = 2'b00;
    for (int t = 8; t < 20; t++) begin
      tick();
      chk("d20_wr_wait", 32'(c_out20), 32'd0);
    end
    tick();
    chk("d20_wr_resp", 32'(c_out20), 32'd1);
    c_in20 = 2'b10;
    a_in20 = 10'd1;
    tick();
    c_in20 = 2'b00;
    chk("d20_rd_accept_busy", 32'(busy20), 32'd1);
    chk("d20_rd_accept_cout", 32'(c_out20), 32'd0);
    for (int t = 22; t < 41; t++) tick();
    chk("d20_rd_pre", 32'(c_out20), 32'd0);
    tick();
    chk("d20_rd_resp", 32'(c_out20), 32'd1);
    chk("d20_rd_beat0", 32'(d_out20), 32'h1110);
    for (int k = 1; k < BEATS; k++) tick();
    chk("d20_rd_beat7", 32'(d_out20), 32'h1F1E);
    tick();
    chk("d20_rd_end_cout", 32'(c_out20), 32'd0);
    chk("d20_rd_end_busy", 32'(busy20), 32'd0);

    // Write line 3 with bytes 00..0F, read it back, then read with a colliding command.
    wr4(10'd3, 8'h00);
    rd4(10'd3, 1'b0);
    rd4(10'd3, 1'b1);

    // Reset during a write keeps beats 0..2 and the old rest of the line.
    wr4(10'd5, 8'h40);
    tick();
    for (int k = 0; k < 3; k++) begin
      c_in = (k == 0) ? 2'b11 : 2'b00;
      a_in = 10'd5;
      d_in = {8'hA0 + 8'(2*k+1), 8'hA0 + 8'(2*k)};
      ref_mem[{10'd5, 4'(2*k)}]   = 8'hA0 + 8'(2*k);
      ref_mem[{10'd5, 4'(2*k+1)}] = 8'hA0 + 8'(2*k+1);
      tick();
    end
    c_in  = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cout", 32'(c_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd4(10'd5, 1'b0);

    // Top line round-trips without touching line 0.
    wr4(10'd0, 8'h10);
    wr4(10'h3FF, 8'h80);
    rd4(10'd0, 1'b0);
    rd4(10'h3FF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
